// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC unit: FSM state encoding and default
// reset vector / sequential step.
package pc_pkg;

  typedef logic [1:0] pc_state_t;

  localparam pc_state_t ST_IDLE = 2'd0;
  localparam pc_state_t ST_RUN  = 2'd1;
  localparam pc_state_t ST_HALT = 2'd2;

  localparam int unsigned PC_STEP_DEFAULT      = 4;
  localparam logic [31:0] PC_RESET_VEC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. Push on a full stack overwrites the oldest
// entry; push together with pop on a non-empty stack replaces the top.
module pc_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_top;
  logic [CW-1:0]   r_count;

  logic            w_empty;
  logic            w_full;
  logic            w_replace;
  logic            w_do_push;
  logic            w_do_pop;
  logic [PW-1:0]   w_wr_idx;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(RAS_DEPTH));
  assign w_replace = i_push && i_pop && !w_empty;
  assign w_do_push = i_push && !w_replace;
  assign w_do_pop  = i_pop && !i_push && !w_empty;
  assign w_wr_idx  = w_replace ? r_top : r_top + 1'b1;

  assign o_top   = r_mem[r_top];
  assign o_empty = w_empty;

  // Entry contents are not reset; only the count gives them meaning.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (w_do_push) begin
      r_top <= r_top + 1'b1;
      if (!w_full) begin
        r_count <= r_count + 1'b1;
      end
    end else if (w_do_pop) begin
      r_top   <= r_top - 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC generator: IDLE/RUN/HALT control, stall-tolerant redirect capture
// and return-address prediction through pc_ras.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC_DEFAULT),
  parameter int unsigned     STEP      = PC_STEP_DEFAULT,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            halt_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            ras_empty_o
);

  pc_state_t       r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_pend_valid;
  logic [XLEN-1:0] r_pend_pc;

  pc_state_t       w_state_next;
  logic            w_run;
  logic            w_adv;
  logic            w_take_redir;
  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_next_pc;
  logic            w_ras_push;
  logic            w_ras_pop;
  logic            w_ras_empty;
  logic [XLEN-1:0] w_ras_top;

  assign w_run        = (r_state == ST_RUN);
  assign w_adv        = w_run && !halt_i && !stall_i;
  assign w_seq_pc     = r_pc + XLEN'(STEP);
  assign w_take_redir = w_adv && (redirect_i || r_pend_valid);
  assign w_redir_pc   = redirect_i ? redirect_pc_i : r_pend_pc;

  // A redirect in the same cycle swallows any call/return on the old path.
  assign w_ras_push = w_adv && !w_take_redir && call_i;
  assign w_ras_pop  = w_adv && !w_take_redir && ret_i && !w_ras_empty;

  always_comb begin
    w_next_pc = r_pc;
    if (w_take_redir) begin
      w_next_pc = w_redir_pc;
    end else if (w_ras_pop) begin
      w_next_pc = w_ras_top;
    end else if (w_adv) begin
      w_next_pc = w_seq_pc;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_IDLE && start_i) begin
      w_state_next = ST_RUN;
    end else if (r_state == ST_RUN && halt_i) begin
      w_state_next = ST_HALT;
    end else if (r_state == ST_HALT && start_i) begin
      w_state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_pc    <= RESET_VEC;
    end else begin
      r_state <= w_state_next;
      r_valid <= (w_state_next == ST_RUN);
      r_pc    <= w_next_pc;
    end
  end

  // A pending target survives HALT and is consumed on the first free RUN cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
    end else if (w_run && !halt_i && stall_i && redirect_i) begin
      r_pend_valid <= 1'b1;
      r_pend_pc    <= redirect_pc_i;
    end else if (w_take_redir) begin
      r_pend_valid <= 1'b0;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_ras_push),
    .i_pop   (w_ras_pop),
    .i_data  (w_seq_pc),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty)
  );

  assign pc_o        = r_pc;
  assign pc_valid_o  = r_valid;
  assign ras_empty_o = w_ras_empty;

endmodule

// File: tb/tb_pc_unit.sv
// Scenario bench for pc_unit: each row drives one cycle of inputs and queues the
// pc_o / pc_valid_o / ras_empty_o values expected one edge later.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_i, start_i, halt_i, stall_i, redirect_i, call_i, ret_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic        pc_valid_o, ras_empty_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rs, st, hl, sl, rd;
    logic [31:0] rpc;
    logic        cl, rt;
    logic [31:0] epc;
    logic        ev, ee;
  } row_t;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        e;
  } exp_t;

  row_t rows[$];
  exp_t sb[$];
  exp_t got;

  always #5 clk = ~clk;

  pc_unit #(
    .XLEN      (32),
    .RESET_VEC (32'h0),
    .STEP      (4),
    .RAS_DEPTH (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .halt_i        (halt_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .call_i        (call_i),
    .ret_i         (ret_i),
    .pc_o          (pc_o),
    .pc_valid_o    (pc_valid_o),
    .ras_empty_o   (ras_empty_o)
  );

  function automatic row_t mk(input logic rs, st, hl, sl, rd, input logic [31:0] rpc,
                              input logic cl, rt, input logic [31:0] epc, input logic ev, ee);
    row_t r;
    r.rs = rs; r.st = st; r.hl = hl; r.sl = sl; r.rd = rd; r.rpc = rpc;
    r.cl = cl; r.rt = rt; r.epc = epc; r.ev = ev; r.ee = ee;
    return r;
  endfunction

  task automatic apply_row(input row_t r);
    exp_t e;
    rst_i = r.rs; start_i = r.st; halt_i = r.hl; stall_i = r.sl;
    redirect_i = r.rd; redirect_pc_i = r.rpc; call_i = r.cl; ret_i = r.rt;
    e.pc = r.epc; e.v = r.ev; e.e = r.ee;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rows.delete();
    rows.push_back(mk(1,0,0,0,0,32'h0,0,0, 32'h0,0,1));
    rows.push_back(mk(1,1,0,0,1,32'h44,1,0, 32'h0,0,1));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      @(posedge clk); #1;
      got = sb.pop_front();
      total++; if (pc_o !== got.pc) begin bad++; $display("FAIL reset[%0d] pc_o actual=%h required=%h", i, pc_o, got.pc); end
      total++; if (pc_valid_o !== got.v) begin bad++; $display("FAIL reset[%0d] pc_valid_o actual=%b required=%b", i, pc_valid_o, got.v); end
      total++; if (ras_empty_o !== got.e) begin bad++; $display("FAIL reset[%0d] ras_empty_o actual=%b required=%b", i, ras_empty_o, got.e); end
    end
  endtask

  task automatic test_sequential();
    rows.delete();
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h0,0,1));
    rows.push_back(mk(0,1,0,0,0,32'h0,0,0, 32'h0,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h4,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h8,1,1));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      @(posedge clk); #1;
      got = sb.pop_front();
      total++; if (pc_o !== got.pc) begin bad++; $display("FAIL seq[%0d] pc_o actual=%h required=%h", i, pc_o, got.pc); end
      total++; if (pc_valid_o !== got.v) begin bad++; $display("FAIL seq[%0d] pc_valid_o actual=%b required=%b", i, pc_valid_o, got.v); end
      total++; if (ras_empty_o !== got.e) begin bad++; $display("FAIL seq[%0d] ras_empty_o actual=%b required=%b", i, ras_empty_o, got.e); end
    end
  endtask

  task automatic test_wrap();
    rows.delete();
    rows.push_back(mk(0,0,0,0,1,32'hFFFF_FFF8,0,0, 32'hFFFF_FFF8,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'hFFFF_FFFC,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h0000_0000,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h0000_0004,1,1));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      @(posedge clk); #1;
      got = sb.pop_front();
      total++; if (pc_o !== got.pc) begin bad++; $display("FAIL wrap[%0d] pc_o actual=%h required=%h", i, pc_o, got.pc); end
      total++; if (pc_valid_o !== got.v) begin bad++; $display("FAIL wrap[%0d] pc_valid_o actual=%b required=%b", i, pc_valid_o, got.v); end
      total++; if (ras_empty_o !== got.e) begin bad++; $display("FAIL wrap[%0d] ras_empty_o actual=%b required=%b", i, ras_empty_o, got.e); end
    end
  endtask

  task automatic test_stall_redirect();
    rows.delete();
    rows.push_back(mk(0,0,0,0,1,32'h10,0,0, 32'h10,1,1));
    rows.push_back(mk(0,0,0,1,0,32'h0,0,0, 32'h10,1,1));
    rows.push_back(mk(0,0,0,1,1,32'h100,0,0, 32'h10,1,1));
    rows.push_back(mk(0,0,0,1,0,32'h0,0,0, 32'h10,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h100,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h104,1,1));
    // newer stalled redirect overwrites the older one
    rows.push_back(mk(0,0,0,1,1,32'h200,0,0, 32'h104,1,1));
    rows.push_back(mk(0,0,0,1,1,32'h300,0,0, 32'h104,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h300,1,1));
    // live redirect on the release cycle beats the pending one
    rows.push_back(mk(0,0,0,1,1,32'h400,0,0, 32'h300,1,1));
    rows.push_back(mk(0,0,0,0,1,32'h500,0,0, 32'h500,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h504,1,1));
    rows.push_back(mk(0,0,0,1,0,32'h0,1,0, 32'h504,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h508,1,1));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      @(posedge clk); #1;
      got = sb.pop_front();
      total++; if (pc_o !== got.pc) begin bad++; $display("FAIL stall[%0d] pc_o actual=%h required=%h", i, pc_o, got.pc); end
      total++; if (pc_valid_o !== got.v) begin bad++; $display("FAIL stall[%0d] pc_valid_o actual=%b required=%b", i, pc_valid_o, got.v); end
      total++; if (ras_empty_o !== got.e) begin bad++; $display("FAIL stall[%0d] ras_empty_o actual=%b required=%b", i, ras_empty_o, got.e); end
    end
  endtask

  task automatic test_ras_overflow();
    rows.delete();
    rows.push_back(mk(0,0,0,0,1,32'h20,0,0, 32'h20,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,1,0, 32'h24,1,0));
    rows.push_back(mk(0,0,0,0,1,32'h40,0,0, 32'h40,1,0));
    rows.push_back(mk(0,0,0,0,0,32'h0,1,0, 32'h44,1,0));
    rows.push_back(mk(0,0,0,0,1,32'h60,0,0, 32'h60,1,0));
    rows.push_back(mk(0,0,0,0,0,32'h0,1,0, 32'h64,1,0));
    rows.push_back(mk(0,0,0,0,1,32'h80,0,0, 32'h80,1,0));
    rows.push_back(mk(0,0,0,0,0,32'h0,1,0, 32'h84,1,0));
    rows.push_back(mk(0,0,0,0,1,32'hA0,0,0, 32'hA0,1,0));
    rows.push_back(mk(0,0,0,0,0,32'h0,1,0, 32'hA4,1,0));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,1, 32'hA4,1,0));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,1, 32'h84,1,0));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,1, 32'h64,1,0));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,1, 32'h44,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,1, 32'h48,1,1));
    rows.push_back(mk(0,0,0,0,1,32'h900,1,0, 32'h900,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h904,1,1));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      @(posedge clk); #1;
      got = sb.pop_front();
      total++; if (pc_o !== got.pc) begin bad++; $display("FAIL ras[%0d] pc_o actual=%h required=%h", i, pc_o, got.pc); end
      total++; if (pc_valid_o !== got.v) begin bad++; $display("FAIL ras[%0d] pc_valid_o actual=%b required=%b", i, pc_valid_o, got.v); end
      total++; if (ras_empty_o !== got.e) begin bad++; $display("FAIL ras[%0d] ras_empty_o actual=%b required=%b", i, ras_empty_o, got.e); end
    end
  endtask

  task automatic test_call_ret();
    rows.delete();
    rows.push_back(mk(0,0,0,0,1,32'h1000,0,0, 32'h1000,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,1,0, 32'h1004,1,0));
    rows.push_back(mk(0,0,0,0,1,32'h2000,0,0, 32'h2000,1,0));
    rows.push_back(mk(0,0,0,0,0,32'h0,1,1, 32'h1004,1,0));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,1, 32'h2004,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,1,1, 32'h2008,1,0));
    rows.push_back(mk(0,0,0,1,0,32'h0,0,1, 32'h2008,1,0));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,1, 32'h2008,1,1));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      @(posedge clk); #1;
      got = sb.pop_front();
      total++; if (pc_o !== got.pc) begin bad++; $display("FAIL callret[%0d] pc_o actual=%h required=%h", i, pc_o, got.pc); end
      total++; if (pc_valid_o !== got.v) begin bad++; $display("FAIL callret[%0d] pc_valid_o actual=%b required=%b", i, pc_valid_o, got.v); end
      total++; if (ras_empty_o !== got.e) begin bad++; $display("FAIL callret[%0d] ras_empty_o actual=%b required=%b", i, ras_empty_o, got.e); end
    end
  endtask

  task automatic test_halt();
    rows.delete();
    rows.push_back(mk(0,0,0,0,1,32'h30,0,0, 32'h30,1,1));
    rows.push_back(mk(0,0,1,0,0,32'h0,0,0, 32'h30,0,1));
    rows.push_back(mk(0,0,0,0,1,32'h500,1,0, 32'h30,0,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,1, 32'h30,0,1));
    rows.push_back(mk(0,1,0,0,0,32'h0,0,0, 32'h30,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h34,1,1));
    // pending target captured before the halt is applied after resuming
    rows.push_back(mk(0,0,0,1,1,32'h600,0,0, 32'h34,1,1));
    rows.push_back(mk(0,0,1,0,0,32'h0,0,0, 32'h34,0,1));
    rows.push_back(mk(0,1,0,0,0,32'h0,0,0, 32'h34,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h600,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h604,1,1));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      @(posedge clk); #1;
      got = sb.pop_front();
      total++; if (pc_o !== got.pc) begin bad++; $display("FAIL halt[%0d] pc_o actual=%h required=%h", i, pc_o, got.pc); end
      total++; if (pc_valid_o !== got.v) begin bad++; $display("FAIL halt[%0d] pc_valid_o actual=%b required=%b", i, pc_valid_o, got.v); end
      total++; if (ras_empty_o !== got.e) begin bad++; $display("FAIL halt[%0d] ras_empty_o actual=%b required=%b", i, ras_empty_o, got.e); end
    end
  endtask

  task automatic test_reset_midflight();
    rows.delete();
    rows.push_back(mk(0,0,0,0,1,32'h50,0,0, 32'h50,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,1,0, 32'h54,1,0));
    rows.push_back(mk(0,0,0,0,0,32'h0,1,0, 32'h58,1,0));
    rows.push_back(mk(0,0,0,1,1,32'h700,0,0, 32'h58,1,0));
    rows.push_back(mk(1,0,0,1,1,32'h800,1,0, 32'h0,0,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h0,0,1));
    rows.push_back(mk(0,1,0,0,0,32'h0,0,0, 32'h0,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,0, 32'h4,1,1));
    rows.push_back(mk(0,0,0,0,0,32'h0,0,1, 32'h8,1,1));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      @(posedge clk); #1;
      got = sb.pop_front();
      total++; if (pc_o !== got.pc) begin bad++; $display("FAIL rstmid[%0d] pc_o actual=%h required=%h", i, pc_o, got.pc); end
      total++; if (pc_valid_o !== got.v) begin bad++; $display("FAIL rstmid[%0d] pc_valid_o actual=%b required=%b", i, pc_valid_o, got.v); end
      total++; if (ras_empty_o !== got.e) begin bad++; $display("FAIL rstmid[%0d] ras_empty_o actual=%b required=%b", i, ras_empty_o, got.e); end
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; halt_i = 1'b0; stall_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; call_i = 1'b0; ret_i = 1'b0;
    test_reset();
    test_sequential();
    test_wrap();
    test_stall_redirect();
    test_ras_overflow();
    test_call_ret();
    test_halt();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter RESET_VEC, default 0, PC value after reset.
REQ-003 Parameter STEP, default 4, sequential PC increment.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 clk_i  input  1  single clock, all state updates on rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 start_i  input  1  begin or resume fetch.
REQ-008 halt_i  input  1  stop fetch, freeze PC.
REQ-009 stall_i  input  1  hold PC this cycle.
REQ-010 redirect_i  input  1  branch/jump resolved, load redirect_pc_i.
REQ-011 redirect_pc_i  input  XLEN  redirect target.
REQ-012 call_i  input  1  current pc_o is a call; push return address.
REQ-013 ret_i  input  1  current pc_o is a return; pop predicted target.
REQ-014 pc_o  output  XLEN  current fetch PC (registered).
REQ-015 pc_valid_o  output  1  pc_o is a valid fetch address.
REQ-016 ras_empty_o  output  1  RAS holds no entries.

Function
REQ-017 FSM SHALL have states IDLE, RUN, HALT; IDLE->RUN on start_i; RUN->HALT on halt_i; HALT->RUN on start_i; all other cases hold state.
REQ-018 pc_valid_o SHALL be 1 exactly when state is RUN (registered, no combinational path from inputs).
REQ-019 In IDLE and HALT pc_o SHALL hold; redirect_i, call_i, ret_i SHALL be ignored, except REQ-024 pending state is retained through HALT.
REQ-020 In RUN, next-PC priority SHALL be: halt_i (hold) > stall_i (hold) > redirect_i or pending redirect > ret_i with non-empty RAS (pop top) > sequential pc_o+STEP.
REQ-021 Sequential increment SHALL wrap modulo 2^XLEN (e.g. 0xFFFFFFFC+4 -> 0x00000000).
REQ-022 Latency: pc_o SHALL reflect the selected next PC one cycle after the qualifying edge.
REQ-023 redirect_i while not stalled SHALL load redirect_pc_i next cycle and SHALL suppress call_i/ret_i in that cycle.
REQ-024 redirect_i while stall_i=1 (RUN) SHALL be captured in a pending register; a later redirect_i before release SHALL overwrite it; on the first non-stalled RUN cycle pending target SHALL load and pending SHALL clear.
REQ-025 redirect_i asserted in the same non-stalled cycle as a pending target SHALL win (newer target), pending cleared.
REQ-026 call_i (RUN, not stalled, no redirect) SHALL push pc_o+STEP; on full RAS SHALL overwrite the oldest entry (circular), count saturating at RAS_DEPTH.
REQ-027 ret_i with empty RAS SHALL be ignored (sequential PC); ret_i with entries SHALL pop, count decrementing.
REQ-028 call_i and ret_i together SHALL load top as next PC and replace top with pc_o+STEP, count unchanged; if RAS empty, push only, sequential PC.
REQ-029 call_i/ret_i under stall_i or halt_i SHALL have no effect on RAS.

Reset
REQ-030 On rst_i=1 at a rising edge: pc_o=RESET_VEC, state=IDLE, pc_valid_o=0, pending cleared, RAS count=0, ras_empty_o=1; RAS data contents need not be cleared.
REQ-031 Reset SHALL override every other input in the same cycle, including mid-stall and mid-pending-redirect.

Structure
REQ-032 Shared package pc_pkg SHALL hold the FSM state typedef (IDLE/RUN/HALT) and default STEP/RESET_VEC constants.
REQ-033 The RAS SHALL be a sub-module pc_ras (push/pop/replace, count, empty/full), parameterised by XLEN and RAS_DEPTH.
REQ-034 Target size 150-300 lines RTL total.

Verification
REQ-035 Reset, then start_i one cycle -> pc_o 0x0 with pc_valid_o=1 next cycle, then 0x4, 0x8 on successive cycles.
REQ-036 RUN at pc 0x10, stall_i 3 cycles with redirect_i=1/0x100 on stall cycle 2 -> pc_o holds 0x10 through stall, becomes 0x100 on first cycle after release.
REQ-037 RAS_DEPTH=4: five calls at 0x20,0x40,0x60,0x80,0xA0 -> four rets yield 0xA4,0x84,0x64,0x44; fifth ret sequential, ras_empty_o=1.
REQ-038 pc_o=0xFFFFFFFC, no stall -> next pc_o 0x00000000.
REQ-039 halt_i at pc 0x30 -> pc_valid_o=0, pc_o holds 0x30 with redirect/call ignored; start_i -> RUN, pc_o 0x34.
REQ-040 rst_i asserted with pending redirect and 2 RAS entries -> pc_o=RESET_VEC, IDLE, ras_empty_o=1, no pending target applied after start_i.
